decode_stage: RTL

//   Instruction decode / operand-fetch stage directly upstream of the ALU.
//   - Accepts 32-bit RV32I instructions from fetch over a valid/ready handshake.
//   - Decodes OP and OP-IMM instructions and reads operands from an integrated 32x32 register file.
//   - Presents registered rs1/rs2/funct3/funct7 to the ALU, plus the rd tag for writeback.
//   - A busy-bit scoreboard stalls read-after-write hazards until writeback.

---
 rtl/riscv_pkg.sv | 54 +++++
 rtl/decode_stage_regfile.sv | 32 +++
 rtl/decode_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the decode stage: opcodes, ALU op
// encodings and a pure decode helper used by the stage.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RIDX  = $clog2(NREGS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_funct3_e;

  typedef struct packed {
    logic            is_op;
    logic            is_op_imm;
    logic            legal;
    logic [RIDX-1:0] rd;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic [2:0]      funct3;
    logic            funct7;
    logic [XLEN-1:0] imm;
  } decode_t;

  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t d;
    d.is_op     = (instr[6:0] == OPC_OP);
    d.is_op_imm = (instr[6:0] == OPC_OP_IMM);
    d.legal     = d.is_op | d.is_op_imm;
    d.rd        = instr[11:7];
    d.rs1       = instr[19:15];
    d.rs2       = instr[24:20];
    d.funct3    = instr[14:12];
    // Immediate forms only carry the SUB/SRA bit for the shift-right group.
    if (d.is_op || (d.funct3 == ALU_SR)) begin
      d.funct7 = instr[30];
    end else begin
      d.funct7 = 1'b0;
    end
    d.imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, x0 reads as zero and ignores writes, synchronous reset to zero.
module decode_stage_regfile
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [RIDX-1:0] raddr1_i,
  input  logic [RIDX-1:0] raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic            we_i,
  input  logic [RIDX-1:0] waddr_i,
  input  logic [XLEN-1:0] wdata_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage feeding the ALU, with a busy-bit scoreboard.
// Define WB_BYPASS_EN to forward the writeback value into a waiting operand.
module decode_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7,
  output logic [4:0]      ex_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  // Handshake: a beat moves on a rising edge where valid & ready are both
  // high; valid never waits on ready, and the producer holds its payload
  // stable while valid is high and ready is low.

  decode_t dec;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [XLEN-1:0] op_a, op_b_reg;
  logic            wb_act, byp1, byp2, hazard, fire;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0] ex_rs2_q, ex_rs2_d;
  logic [2:0]      ex_funct3_q, ex_funct3_d;
  logic            ex_funct7_q, ex_funct7_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic            illegal_q, illegal_d;
  logic [NREGS-1:0] busy_q, busy_d;

  assign dec    = decode_instr(if_instr);
  assign wb_act = wb_en && (wb_rd != '0);

  decode_stage_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (dec.rs1),
    .raddr2_i (dec.rs2),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2),
    .we_i     (wb_act),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_data)
  );

  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef WB_BYPASS_EN
    byp1 = wb_act && (wb_rd == dec.rs1);
    byp2 = wb_act && (wb_rd == dec.rs2);
`endif
  end

  assign op_a     = byp1 ? wb_data : rf_rdata1;
  assign op_b_reg = byp2 ? wb_data : rf_rdata2;

  // busy_q[0] is held at zero, so x0 sources never stall.
  assign hazard   = (busy_q[dec.rs1] && !byp1) ||
                    (dec.is_op && busy_q[dec.rs2] && !byp2);
  assign if_ready = (!ex_valid_q || ex_ready) && !hazard;
  assign fire     = if_valid && if_ready;

  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_funct3_d = ex_funct3_q;
    ex_funct7_d = ex_funct7_q;
    ex_rd_d     = ex_rd_q;
    illegal_d   = 1'b0;

    if (fire && dec.legal) begin
      ex_valid_d  = 1'b1;
      ex_rs1_d    = op_a;
      ex_rs2_d    = dec.is_op ? op_b_reg : dec.imm;
      ex_funct3_d = dec.funct3;
      ex_funct7_d = dec.funct7;
      ex_rd_d     = dec.rd;
    end else if (fire) begin
      ex_valid_d = 1'b0;
      illegal_d  = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  // Writeback clears first so an issue to the same rd on this edge wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_act) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (fire && dec.legal && (dec.rd != '0)) begin
      busy_d[dec.rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_funct3_q <= '0;
      ex_funct7_q <= 1'b0;
      ex_rd_q     <= '0;
      illegal_q   <= 1'b0;
      busy_q      <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_funct3_q <= ex_funct3_d;
      ex_funct7_q <= ex_funct7_d;
      ex_rd_q     <= ex_rd_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_rs1    = ex_rs1_q;
  assign ex_rs2    = ex_rs2_q;
  assign ex_funct3 = ex_funct3_q;
  assign ex_funct7 = ex_funct7_q;
  assign ex_rd     = ex_rd_q;
  assign illegal   = illegal_q;

endmodule
